// File: rtl/spi_slave_wishbone_master_if.sv
// Wishbone classic bus bundle between the SPI-driven bridge (master side)
// and the local register space (slave side).
interface spi_slave_wishbone_master_if #(
    parameter int ADDR_W = 7
);
    logic              CYC_O;
    logic              STB_O;
    logic              WE_O;
    logic [ADDR_W-1:0] ADR_O;
    logic [7:0]        DAT_O;
    logic [7:0]        DAT_I;
    logic              ACK_I;
    logic              RTY_I;

    modport master (
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        input  DAT_I, ACK_I, RTY_I
    );

    modport slave (
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        output DAT_I, ACK_I, RTY_I
    );
endinterface

// File: rtl/spi_slave_wishbone_master.sv
// SPI mode-0 peripheral that turns {rw, addr} command frames from a remote SPI
// master into Wishbone cycles, with read prefetch, retry/timeout and sticky status.
module spi_slave_wishbone_master #(
    parameter int ADDR_W    = 7,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic                               CLK_I,
    input  logic                               reset,
    input  logic                               sck,
    input  logic                               cs_n,
    input  logic                               mosi,
    output logic                               miso,
    output logic                               miso_oe,
    spi_slave_wishbone_master_if.master        wb,
    output logic [2:0]                         status
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0]  TIMEOUT_C   = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
    localparam logic [RTY_W-1:0]  MAX_RETRY_C = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RTY_ONE     = RTY_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    typedef enum logic [0:0] {
        FR_CMD  = 1'b0,
        FR_DATA = 1'b1
    } frame_t;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_ACCESS    = 2'd1,
        WB_RETRY_GAP = 2'd2
    } wb_state_t;

    // Pin synchronisers and edge-detect stages
    logic sck_meta_r, sck_sync_r, sck_d_r;
    logic cs_meta_r, cs_sync_r, cs_d_r;
    logic mosi_meta_r, mosi_sync_r;

    // Framer state
    frame_t            frame_r;
    logic [2:0]        bit_cnt_r;
    logic [6:0]        rx_shift_r;
    logic [7:0]        tx_shift_r;
    logic              cmd_rw_r;
    logic [ADDR_W-1:0] addr_ptr_r;
    logic              rd_wait_r;
    logic              miso_r;
    logic              miso_oe_r;

    // Wishbone master state
    wb_state_t         wb_state_r;
    logic              cyc_r, stb_r, we_r;
    logic [ADDR_W-1:0] adr_r;
    logic [7:0]        dat_r;
    logic [TMR_W-1:0]  timer_r;
    logic [RTY_W-1:0]  retry_r;

    logic [2:0]        status_r;

    // Decoded events
    logic              sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, sel_s;
    logic              byte_done_s;
    logic [7:0]        rx_byte_s;
    logic [7:0]        status_byte_s;
    logic              req_s, req_we_s;
    logic [ADDR_W-1:0] req_adr_s;
    logic [7:0]        req_dat_s;
    logic              req_accept_s, req_drop_s;
    logic              rd_ack_s;
    logic              first_fall_s;
    logic              late_fall_s;
    logic              timeout_set_s;
    logic [2:0]        set_vec_s;

    assign sck_rise_s    = sck_sync_r & ~sck_d_r;
    assign sck_fall_s    = ~sck_sync_r & sck_d_r;
    assign cs_fall_s     = ~cs_sync_r & cs_d_r;
    assign cs_rise_s     = cs_sync_r & ~cs_d_r;
    assign sel_s         = ~cs_sync_r;
    assign rx_byte_s     = {rx_shift_r, mosi_sync_r};
    assign byte_done_s   = sck_rise_s & sel_s & ~cs_fall_s & (bit_cnt_r == 3'd7);
    assign status_byte_s = {5'b00000, status_r};

    assign req_accept_s  = req_s & (wb_state_r == WB_IDLE);
    assign req_drop_s    = req_s & (wb_state_r != WB_IDLE);
    assign rd_ack_s      = (wb_state_r == WB_ACCESS) & wb.ACK_I & ~we_r;

    // First sck fall of a byte is where a prefetched read byte must be ready
    assign first_fall_s  = sel_s & ~cs_fall_s & sck_fall_s & (bit_cnt_r == 3'd0);
    assign late_fall_s   = first_fall_s & rd_wait_r & ~rd_ack_s;

    assign set_vec_s     = {req_drop_s & req_we_s,
                            timeout_set_s,
                            late_fall_s | (req_drop_s & ~req_we_s)};

    // Two-flop synchronisers, plus a third flop on sck and cs_n for edges
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_d_r     <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_d_r      <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_d_r     <= sck_sync_r;
            cs_meta_r   <= cs_n;
            cs_sync_r   <= cs_meta_r;
            cs_d_r      <= cs_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Request decode: what Wishbone access (if any) a completed byte asks for
    always_comb begin
        req_s     = 1'b0;
        req_we_s  = 1'b0;
        req_adr_s = '0;
        req_dat_s = 8'h00;
        if (byte_done_s) begin
            if (frame_r == FR_CMD) begin
                req_s     = rx_byte_s[7];
                req_adr_s = ADDR_W'(rx_byte_s[6:0]);
            end else if (cmd_rw_r) begin
                req_s     = 1'b1;
                req_adr_s = addr_ptr_r + ADDR_ONE;
            end else begin
                req_s     = 1'b1;
                req_we_s  = 1'b1;
                req_adr_s = addr_ptr_r;
                req_dat_s = rx_byte_s;
            end
        end else begin
            req_s = 1'b0;
        end
    end

    // Framer: bit counting, command decode, address pointer and MISO shifter
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            frame_r    <= FR_CMD;
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 7'h00;
            tx_shift_r <= 8'h00;
            cmd_rw_r   <= 1'b0;
            addr_ptr_r <= '0;
            rd_wait_r  <= 1'b0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else if (cs_fall_s) begin
            // Bit 7 of the status byte goes straight to miso, so preload the rest
            frame_r    <= FR_CMD;
            bit_cnt_r  <= 3'd0;
            tx_shift_r <= {status_byte_s[6:0], 1'b0};
            miso_r     <= status_byte_s[7];
            miso_oe_r  <= 1'b1;
            rd_wait_r  <= 1'b0;
        end else if (cs_rise_s) begin
            frame_r    <= FR_CMD;
            bit_cnt_r  <= 3'd0;
            miso_oe_r  <= 1'b0;
            rd_wait_r  <= 1'b0;
        end else begin
            if (sel_s && sck_rise_s) begin
                rx_shift_r <= rx_byte_s[6:0];
                bit_cnt_r  <= bit_cnt_r + 3'd1;
            end
            if (byte_done_s) begin
                if (frame_r == FR_CMD) begin
                    cmd_rw_r   <= rx_byte_s[7];
                    addr_ptr_r <= ADDR_W'(rx_byte_s[6:0]);
                    frame_r    <= FR_DATA;
                end else begin
                    addr_ptr_r <= addr_ptr_r + ADDR_ONE;
                end
            end
            if (first_fall_s && rd_wait_r) begin
                if (rd_ack_s) begin
                    miso_r     <= wb.DAT_I[7];
                    tx_shift_r <= {wb.DAT_I[6:0], 1'b0};
                end else begin
                    miso_r     <= 1'b0;
                    tx_shift_r <= 8'h00;
                end
                rd_wait_r <= 1'b0;
            end else if (sel_s && sck_fall_s) begin
                miso_r     <= tx_shift_r[7];
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else if (rd_ack_s && rd_wait_r) begin
                tx_shift_r <= wb.DAT_I;
                rd_wait_r  <= 1'b0;
            end else if (req_drop_s && !req_we_s) begin
                tx_shift_r <= 8'h00;
            end
            if (req_accept_s && !req_we_s) begin
                rd_wait_r <= 1'b1;
            end
        end
    end

    // Abandon condition: retries exhausted or no response within TIMEOUT
    always_comb begin
        timeout_set_s = 1'b0;
        if (wb_state_r == WB_ACCESS && !wb.ACK_I) begin
            if (wb.RTY_I) begin
                timeout_set_s = (retry_r >= MAX_RETRY_C);
            end else begin
                timeout_set_s = (timer_r == TIMEOUT_C);
            end
        end else begin
            timeout_set_s = 1'b0;
        end
    end

    // Wishbone master: one outstanding cycle with bounded retry and timeout
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            wb_state_r <= WB_IDLE;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            adr_r      <= '0;
            dat_r      <= 8'h00;
            timer_r    <= '0;
            retry_r    <= '0;
        end else begin
            case (wb_state_r)
                WB_IDLE: begin
                    if (req_s) begin
                        cyc_r      <= 1'b1;
                        stb_r      <= 1'b1;
                        we_r       <= req_we_s;
                        adr_r      <= req_adr_s;
                        dat_r      <= req_dat_s;
                        timer_r    <= '0;
                        retry_r    <= '0;
                        wb_state_r <= WB_ACCESS;
                    end
                end
                WB_ACCESS: begin
                    if (wb.ACK_I) begin
                        cyc_r      <= 1'b0;
                        stb_r      <= 1'b0;
                        wb_state_r <= WB_IDLE;
                    end else if (wb.RTY_I) begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                        if (retry_r < MAX_RETRY_C) begin
                            retry_r    <= retry_r + RTY_ONE;
                            wb_state_r <= WB_RETRY_GAP;
                        end else begin
                            wb_state_r <= WB_IDLE;
                        end
                    end else if (timer_r == TIMEOUT_C) begin
                        cyc_r      <= 1'b0;
                        stb_r      <= 1'b0;
                        wb_state_r <= WB_IDLE;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                WB_RETRY_GAP: begin
                    cyc_r      <= 1'b1;
                    stb_r      <= 1'b1;
                    timer_r    <= '0;
                    wb_state_r <= WB_ACCESS;
                end
                default: begin
                    cyc_r      <= 1'b0;
                    stb_r      <= 1'b0;
                    wb_state_r <= WB_IDLE;
                end
            endcase
        end
    end

    // Sticky status; a set in the clearing cycle survives the clear
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            status_r <= 3'b000;
        end else if (cs_fall_s) begin
            status_r <= set_vec_s;
        end else begin
            status_r <= status_r | set_vec_s;
        end
    end

    assign miso     = miso_r;
    assign miso_oe  = miso_oe_r;
    assign status   = status_r;
    assign wb.CYC_O = cyc_r;
    assign wb.STB_O = stb_r;
    assign wb.WE_O  = we_r;
    assign wb.ADR_O = adr_r;
    assign wb.DAT_O = dat_r;

endmodule

// File: tb/tb_spi_slave_wishbone_master.sv
// Scoreboard bench: expected Wishbone cycles and MISO bytes are queued with the
// stimulus; monitors pop and compare when the DUT strobes a cycle or a byte completes.
module tb_spi_slave_wishbone_master;

    logic       CLK_I = 1'b0;
    logic       reset = 1'b1;
    logic       sck   = 1'b0;
    logic       cs_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [2:0] status;

    spi_slave_wishbone_master_if #(.ADDR_W(7)) wb ();

    spi_slave_wishbone_master #(
        .ADDR_W(7),
        .TIMEOUT(255),
        .MAX_RETRY(3)
    ) dut (
        .CLK_I  (CLK_I),
        .reset  (reset),
        .sck    (sck),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .miso_oe(miso_oe),
        .wb     (wb),
        .status (status)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct packed {
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] miso_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] mem [0:127];
    int         ack_delay = 2;
    bit         rty_mode  = 1'b0;
    int         wcnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic we, input logic [6:0] adr, input logic [7:0] dat);
        wb_exp_t e;
        e.we  = we;
        e.adr = adr;
        e.dat = dat;
        wb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            tick(half);
            sck = 1'b1;
            tick(half);
            sck = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        tick(8);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"},  wb.CYC_O, 1'b0);
        check({tag, "_stb"},  wb.STB_O, 1'b0);
        check({tag, "_we"},   wb.WE_O, 1'b0);
        check({tag, "_adr"},  wb.ADR_O, 7'h00);
        check({tag, "_dat"},  wb.DAT_O, 8'h00);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_oe"},   miso_oe, 1'b0);
        check({tag, "_stat"}, status, 3'b000);
    endtask

    // Wishbone slave model: ACK after ack_delay cycles, or RTY every strobe cycle
    initial begin
        wb.ACK_I = 1'b0;
        wb.RTY_I = 1'b0;
        wb.DAT_I = 8'h00;
        forever begin
            @(posedge CLK_I);
            #1;
            wb.ACK_I = 1'b0;
            wb.RTY_I = 1'b0;
            if (wb.CYC_O === 1'b1 && wb.STB_O === 1'b1) begin
                if (rty_mode) begin
                    wb.RTY_I = 1'b1;
                end else if (wcnt == ack_delay) begin
                    wb.ACK_I = 1'b1;
                    wb.DAT_I = mem[wb.ADR_O];
                    if (wb.WE_O) mem[wb.ADR_O] = wb.DAT_O;
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    // Wishbone monitor: every new strobe must match the head of the queue
    logic    stb_prev = 1'b0;
    wb_exp_t wb_e;
    initial begin
        forever begin
            @(negedge CLK_I);
            if (wb.STB_O === 1'b1 && stb_prev == 1'b0) begin
                if (wb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_unexpected: got we=%0b adr=0x%0h dat=0x%0h, expected no cycle",
                             wb.WE_O, wb.ADR_O, wb.DAT_O);
                end else begin
                    wb_e = wb_q.pop_front();
                    check("wb_we", wb.WE_O, wb_e.we);
                    check("wb_adr", wb.ADR_O, wb_e.adr);
                    if (wb_e.we) check("wb_dat", wb.DAT_O, wb_e.dat);
                end
            end
            stb_prev = (wb.STB_O === 1'b1);
        end
    end

    // MISO monitor: sample on sck rise, compare each complete byte
    int         mon_nb = 0;
    logic [7:0] mon_sh = 8'h00;
    initial begin
        forever begin
            @(posedge sck or posedge cs_n);
            if (cs_n) begin
                mon_nb = 0;
            end else begin
                mon_sh = {mon_sh[6:0], miso};
                mon_nb++;
                if (mon_nb == 8) begin
                    mon_nb = 0;
                    check("miso_oe", miso_oe, 1'b1);
                    if (miso_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL miso_unexpected: got 0x%0h, expected no byte", mon_sh);
                    end else begin
                        check("miso_byte", mon_sh, miso_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        mem[7'h10] = 8'h5A;
        mem[7'h11] = 8'hC3;
        mem[7'h12] = 8'h77;

        tick(5);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(5);

        // Write burst: two writes with auto-increment
        ack_delay = 2;
        exp_wb(1'b1, 7'h05, 8'h3C);
        exp_wb(1'b1, 7'h06, 8'hA7);
        miso_q.push_back(8'h00); miso_q.push_back(8'h00); miso_q.push_back(8'h00);
        frame_start();
        spi_bits(8'h05, 8, 8);
        spi_bits(8'h3C, 8, 8);
        spi_bits(8'hA7, 8, 8);
        frame_end();
        tick(20);
        check("wr_status", status, 3'b000);
        check("wr_mem06", mem[7'h06], 8'hA7);

        // Read with prefetch
        exp_wb(1'b0, 7'h10, 8'h00);
        exp_wb(1'b0, 7'h11, 8'h00);
        exp_wb(1'b0, 7'h12, 8'h00);
        miso_q.push_back(8'h00); miso_q.push_back(8'h5A); miso_q.push_back(8'hC3);
        frame_start();
        spi_bits(8'h90, 8, 8);
        spi_bits(8'h00, 8, 8);
        spi_bits(8'h00, 8, 8);
        frame_end();
        tick(20);
        check("rd_status", status, 3'b000);

        // Retry exhaustion: initial attempt plus three retries, then abandoned
        rty_mode = 1'b1;
        for (int i = 0; i < 4; i++) exp_wb(1'b1, 7'h01, 8'h99);
        miso_q.push_back(8'h00); miso_q.push_back(8'h00);
        frame_start();
        spi_bits(8'h01, 8, 8);
        spi_bits(8'h99, 8, 8);
        frame_end();
        tick(60);
        check("rty_status", status, 3'b010);
        check("rty_cyc", wb.CYC_O, 1'b0);
        rty_mode = 1'b0;

        // Next frame reports the timeout, then the flag clears
        miso_q.push_back(8'h02);
        frame_start();
        spi_bits(8'h20, 8, 8);
        frame_end();
        tick(10);
        check("rty_cleared", status, 3'b000);

        // Late read at CLK/8: data byte shifts out as zero
        ack_delay = 200;
        exp_wb(1'b0, 7'h00, 8'h00);
        miso_q.push_back(8'h00); miso_q.push_back(8'h00);
        frame_start();
        spi_bits(8'h80, 8, 4);
        spi_bits(8'h00, 8, 4);
        frame_end();
        tick(250);
        check("late_status", status, 3'b001);

        // Overflow: second write arrives while the first is still waiting
        ack_delay = 100;
        exp_wb(1'b1, 7'h00, 8'h11);
        miso_q.push_back(8'h01); miso_q.push_back(8'h00); miso_q.push_back(8'h00);
        frame_start();
        spi_bits(8'h00, 8, 4);
        spi_bits(8'h11, 8, 4);
        spi_bits(8'h22, 8, 4);
        frame_end();
        tick(150);
        check("ovf_status", status, 3'b100);
        check("ovf_mem00", mem[7'h00], 8'h11);

        // Abort: partial byte then cs_n high; reset while the write is in flight
        ack_delay = 1000;
        exp_wb(1'b1, 7'h03, 8'h55);
        miso_q.push_back(8'h04); miso_q.push_back(8'h00);
        frame_start();
        spi_bits(8'h03, 8, 4);
        spi_bits(8'h55, 8, 4);
        spi_bits(8'hF0, 4, 4);
        cs_n = 1'b1;
        tick(10);
        check("abort_inflight", wb.CYC_O, 1'b1);
        check("abort_oe", miso_oe, 1'b0);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("abort_rst");
        reset = 1'b0;
        ack_delay = 2;
        tick(40);
        check("abort_idle", wb.CYC_O, 1'b0);

        check("wb_q_drained", wb_q.size(), 0);
        check("miso_q_drained", miso_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
